majority_bist_ctrl: RTL and testbench

Built-in self-test sequencer for the N-input majority voter (`majority`: input bus `mp`, output `m`).
- On a start pulse, sweeps every input pattern of the voter and waits for the voter output to settle.
- Compares `m` against an internal golden majority and reports pass/fail, an error count and the first failing pattern.
- Sits beside the voter; drives the voter's `mp` in place of a testbench or functional source.

---
 rtl/majority_bist_pkg.sv | 29 ++
 rtl/maj_golden.sv | 13 +
 rtl/majority_bist_ctrl.sv | 121 ++++++++++++
 tb/tb_majority_bist_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/majority_bist_pkg.sv
// Shared types and helpers for the majority voter BIST sequencer.
// The reference popcount-majority function is usable by RTL and benches alike.
package majority_bist_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Widest voter the reference function can model.
  localparam int MAX_N = 32;

  // The error counter is one bit wider than the voter input.
  function automatic int err_w(input int n);
    return n + 1;
  endfunction

  function automatic logic maj_golden(input logic [MAX_N-1:0] pattern, input int n);
    int ones;
    ones = 0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n) ones += int'(pattern[i]);
    end
    return (ones > n / 2);
  endfunction

endpackage

// File: rtl/maj_golden.sv
// Combinational reference majority voter used as the BIST golden model.
module maj_golden #(
  parameter int N = 3
) (
  input  logic [N-1:0] pat,
  output logic         golden
);

  localparam int MAXN = majority_bist_pkg::MAX_N;

  assign golden = majority_bist_pkg::maj_golden(MAXN'(pat), N);

endmodule

// File: rtl/majority_bist_ctrl.sv
// BIST sequencer sweeping all input patterns of an N-input majority voter.
// Optional macro MAJ_BIST_INJECT_EN adds an `inject` port that flips the golden value for all-ones.
module majority_bist_ctrl
  import majority_bist_pkg::*;
#(
  parameter int N        = 3,
  parameter int WAIT_CYC = 1,
  parameter int LOOPS    = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
`ifdef MAJ_BIST_INJECT_EN
  input  logic                inject,
`endif
  output logic [N-1:0]        mp,
  input  logic                m,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [err_w(N)-1:0] err_cnt,
  output logic [N-1:0]        fail_pat,
  output state_t              dbg_state
);

  localparam int EW = err_w(N);
  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int LW = (LOOPS > 1) ? $clog2(LOOPS) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_CYC - 1);
  localparam logic [LW-1:0] LOOP_LAST = LW'(LOOPS - 1);

  state_t          state;
  logic [WW-1:0]   wait_cnt;
  logic [LW-1:0]   loop_cnt;
  logic            gold_raw;
  logic            golden;
  logic            mismatch;
  logic [EW-1:0]   err_next;
  logic            last_pat;

  maj_golden #(.N(N)) u_golden (
    .pat    (mp),
    .golden (gold_raw)
  );

`ifdef MAJ_BIST_INJECT_EN
  logic inject_q;

  // Deliberately wrong expectation on all-ones proves the compare path can flag errors.
  assign golden = gold_raw ^ (inject_q & (&mp));
`else
  assign golden = gold_raw;
`endif

  assign mismatch  = (m != golden);
  assign err_next  = (mismatch && !(&err_cnt)) ? err_cnt + EW'(1) : err_cnt;
  assign last_pat  = (&mp) && (loop_cnt == LOOP_LAST);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      mp       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      err_cnt  <= '0;
      fail_pat <= '0;
      wait_cnt <= '0;
      loop_cnt <= '0;
`ifdef MAJ_BIST_INJECT_EN
      inject_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state    <= APPLY;
            mp       <= '0;
            busy     <= 1'b1;
            err_cnt  <= '0;
            fail_pat <= '0;
            pass     <= 1'b0;
            wait_cnt <= '0;
            loop_cnt <= '0;
`ifdef MAJ_BIST_INJECT_EN
            inject_q <= inject;
`endif
          end
        end
        APPLY: begin
          if (wait_cnt == WAIT_LAST) state <= SAMPLE;
          else wait_cnt <= wait_cnt + WW'(1);
        end
        SAMPLE: begin
          err_cnt <= err_next;
          // A zero count means nothing has failed yet in this run.
          if (mismatch && (err_cnt == '0)) fail_pat <= mp;
          if (last_pat) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_next == '0);
          end else begin
            mp       <= mp + N'(1);
            wait_cnt <= '0;
            if (&mp) loop_cnt <= loop_cnt + LW'(1);
            state    <= APPLY;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_majority_bist_ctrl.sv
// Directed bench for majority_bist_ctrl: good, stuck-at-0 and inverted voter models.
module tb_majority_bist_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start1, start2;
  logic       m1, m2;
  logic [2:0] mp1, mp2, fail1, fail2;
  logic [3:0] err1, err2;
  logic       busy1, busy2, done1, done2, pass1, pass2;
  logic [1:0] dbg1, dbg2;
`ifdef MAJ_BIST_INJECT_EN
  logic       inject;
`endif

  int mode1, mode2;
  int n_pass  = 0;
  int n_total = 0;
  int bcyc, seq_bad, k, done_seen;

  // Voter models: 0 = correct, 1 = stuck-at-0, 2 = inverted.
  function automatic logic voter(input logic [2:0] p, input int mode);
    logic good;
    good = ($countones(p) >= 2);
    case (mode)
      1:       return 1'b0;
      2:       return ~good;
      default: return good;
    endcase
  endfunction

  always_comb m1 = voter(mp1, mode1);
  always_comb m2 = voter(mp2, mode2);

  majority_bist_ctrl #(.N(3), .WAIT_CYC(1), .LOOPS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
`ifdef MAJ_BIST_INJECT_EN
    .inject(inject),
`endif
    .mp(mp1), .m(m1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_pat(fail1), .dbg_state(dbg1)
  );

  majority_bist_ctrl #(.N(3), .WAIT_CYC(3), .LOOPS(40)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2),
`ifdef MAJ_BIST_INJECT_EN
    .inject(1'b0),
`endif
    .mp(mp2), .m(m2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_pat(fail2), .dbg_state(dbg2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_total++;
    assert (obs === exp_v) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
  endtask

  function automatic logic busy_of(input int w);
    return (w == 2) ? busy2 : busy1;
  endfunction

  function automatic logic [2:0] mp_of(input int w);
    return (w == 2) ? mp2 : mp1;
  endfunction

  function automatic logic [3:0] err_of(input int w);
    return (w == 2) ? err2 : err1;
  endfunction

  // Drive start across one rising edge; leaves start high when hold is set.
  task automatic pulse(input int w, input int hold);
    @(negedge clk);
    if (w == 2) start2 = 1'b1; else start1 = 1'b1;
    @(negedge clk);
    if (hold == 0) begin
      if (w == 2) start2 = 1'b0; else start1 = 1'b0;
    end
  endtask

  // Called on the first busy cycle; returns on the first non-busy cycle.
  task automatic run(input int w, input int waitc, input int limit, input int hold,
                     input int repulse_at, output int cycles, output int bad);
    cycles = 0;
    bad    = 0;
    while (busy_of(w) && cycles < limit) begin
      if (mp_of(w) !== 3'((cycles / (waitc + 1)) % 8)) bad++;
      if (cycles == 0 && err_of(w) !== 4'd0) bad++;
      if (w == 1 && hold == 0) start1 = (cycles == repulse_at);
      cycles++;
      @(negedge clk);
    end
    if (w == 1 && hold == 0) start1 = 1'b0;
  endtask

  initial begin
    rst_n  = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    mode1  = 0;
    mode2  = 0;
`ifdef MAJ_BIST_INJECT_EN
    inject = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("rst_mp", 32'(mp1), 0);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_done", 32'(done1), 0);
    chk("rst_pass", 32'(pass1), 0);
    chk("rst_err", 32'(err1), 0);
    chk("rst_fail", 32'(fail1), 0);
    chk("rst_state", 32'(dbg1), 0);
    rst_n = 1'b1;

    // Good voter, single sweep.
    pulse(1, 0);
    chk("t1_busy_rise", 32'(busy1), 1);
    run(1, 1, 40, 0, -1, bcyc, seq_bad);
    chk("t1_busy_cycles", 32'(bcyc), 16);
    chk("t1_sequence", 32'(seq_bad), 0);
    chk("t1_done", 32'(done1), 1);
    chk("t1_state_done", 32'(dbg1), 3);
    chk("t1_pass", 32'(pass1), 1);
    chk("t1_err", 32'(err1), 0);
    chk("t1_fail", 32'(fail1), 0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done1), 0);

    // Stuck-at-0 voter fails on 3, 5, 6, 7.
    mode1 = 1;
    pulse(1, 0);
    run(1, 1, 40, 0, -1, bcyc, seq_bad);
    chk("t2_err", 32'(err1), 4);
    chk("t2_fail", 32'(fail1), 3);
    chk("t2_pass", 32'(pass1), 0);

    // Inverted voter fails everywhere, first at pattern 0.
    mode1 = 2;
    pulse(1, 0);
    run(1, 1, 40, 0, -1, bcyc, seq_bad);
    chk("t3_err", 32'(err1), 8);
    chk("t3_fail", 32'(fail1), 0);
    chk("t3_pass", 32'(pass1), 0);

    // Start re-pulsed mid-run is ignored.
    mode1 = 0;
    pulse(1, 0);
    run(1, 1, 40, 0, 5, bcyc, seq_bad);
    chk("t4_busy_cycles", 32'(bcyc), 16);
    chk("t4_sequence", 32'(seq_bad), 0);
    chk("t4_pass", 32'(pass1), 1);
    repeat (5) @(negedge clk);
    chk("t4_idle_busy", 32'(busy1), 0);
    chk("t4_idle_pass_stable", 32'(pass1), 1);

    // Start held high: a second run follows with cleared results.
    mode1 = 1;
    pulse(1, 1);
    run(1, 1, 40, 1, -1, bcyc, seq_bad);
    chk("t4h_busy_cycles", 32'(bcyc), 16);
    chk("t4h_err", 32'(err1), 4);
    k = 0;
    while (!busy1 && k < 4) begin
      @(negedge clk);
      k++;
    end
    chk("t4h_restart_busy", 32'(busy1), 1);
    chk("t4h_restart_err", 32'(err1), 0);
    chk("t4h_restart_fail", 32'(fail1), 0);
    chk("t4h_restart_pass", 32'(pass1), 0);
    start1 = 1'b0;
    mode1  = 0;
    run(1, 1, 40, 0, -1, bcyc, seq_bad);
    chk("t4h_second_cycles", 32'(bcyc), 16);
    chk("t4h_second_pass", 32'(pass1), 1);

    // Asynchronous reset during pattern 4.
    mode1 = 1;
    pulse(1, 0);
    k = 0;
    while (mp1 !== 3'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk("t5_reached_pat4", 32'(mp1), 4);
    chk("t5_err_before", 32'(err1), 1);
    rst_n = 1'b0;
    #1;
    chk("t5_async_mp", 32'(mp1), 0);
    chk("t5_async_busy", 32'(busy1), 0);
    chk("t5_async_err", 32'(err1), 0);
    chk("t5_async_fail", 32'(fail1), 0);
    chk("t5_async_state", 32'(dbg1), 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done1) done_seen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done1) done_seen++;
    end
    chk("t5_no_done", 32'(done_seen), 0);
    chk("t5_pass_low", 32'(pass1), 0);
    mode1 = 0;
    pulse(1, 0);
    run(1, 1, 40, 0, -1, bcyc, seq_bad);
    chk("t5_clean_cycles", 32'(bcyc), 16);
    chk("t5_clean_pass", 32'(pass1), 1);

    // 40 sweeps, 3 settle cycles, stuck-at-0: 160 errors saturate at 15.
    mode2 = 1;
    pulse(2, 0);
    run(2, 3, 2000, 0, -1, bcyc, seq_bad);
    chk("t6_busy_cycles", 32'(bcyc), 1280);
    chk("t6_sequence", 32'(seq_bad), 0);
    chk("t6_done", 32'(done2), 1);
    chk("t6_err_sat", 32'(err2), 15);
    chk("t6_fail", 32'(fail2), 3);
    chk("t6_pass", 32'(pass2), 0);

`ifdef MAJ_BIST_INJECT_EN
    // Injected golden error on all-ones with a correct voter.
    mode1  = 0;
    inject = 1'b1;
    pulse(1, 0);
    inject = 1'b0;
    run(1, 1, 40, 0, -1, bcyc, seq_bad);
    chk("inj_err", 32'(err1), 1);
    chk("inj_fail", 32'(fail1), 7);
    chk("inj_pass", 32'(pass1), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
